// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: latches a pending HI/LO result,
// holds busy for a fixed latency, then commits. Optional cancel port via `MD_CANCEL_EN.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs_data,
  input  logic [31:0] e_rt_data,
  input  logic        d_md_use,
`ifdef MD_CANCEL_EN
  input  logic        md_cancel,
`endif
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_dz_q, pend_dz_d;

  logic        cancel;
  logic        is_mult;
  logic        is_div;
  logic        dz;

`ifdef MD_CANCEL_EN
  assign cancel = md_cancel;
`else
  assign cancel = 1'b0;
`endif

  assign is_mult = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
  assign is_div  = (e_md_op == OP_DIV)  || (e_md_op == OP_DIVU);
  assign dz      = (e_rt_data == 32'd0);

  assign start    = ~reset & e_valid & (is_mult | is_div) & (state_q == IDLE) & ~cancel;
  assign stall_md = ~reset & d_md_use & (start | busy_q);
  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Operand datapath. Division runs on magnitudes so the signed case truncates
  // toward zero and the remainder follows the dividend's sign.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] dvs;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  always_comb begin
    prod_s = {{32{e_rs_data[31]}}, e_rs_data} * {{32{e_rt_data[31]}}, e_rt_data};
    prod_u = {32'd0, e_rs_data} * {32'd0, e_rt_data};
    dvs    = dz ? 32'd1 : e_rt_data;
    rs_mag = e_rs_data[31] ? (~e_rs_data + 32'd1) : e_rs_data;
    rt_mag = dvs[31] ? (~dvs + 32'd1) : dvs;
    q_mag  = rs_mag / rt_mag;
    r_mag  = rs_mag % rt_mag;
    q_s    = (e_rs_data[31] ^ dvs[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = e_rs_data[31] ? (~r_mag + 32'd1) : r_mag;
    q_u    = e_rs_data / dvs;
    r_u    = e_rs_data % dvs;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          cnt_d     = is_mult ? MULT_N : DIV_N;
          pend_dz_d = is_div & dz;
          case (e_md_op)
            OP_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
            OP_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
            OP_DIV: begin
              pend_hi_d = r_s;
              pend_lo_d = q_s;
            end
            default: begin
              pend_hi_d = r_u;
              pend_lo_d = q_u;
            end
          endcase
        end else if (e_valid && !cancel) begin
          if (e_md_op == OP_MTHI) hi_d = e_rs_data;
          if (e_md_op == OP_MTLO) lo_d = e_rs_data;
        end
      end

      RUN: begin
        if (cancel || cnt_q == 4'd1) begin
          // Both paths leave RUN; only a natural finish with a legal divisor commits.
          if (!cancel && !pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d   = IDLE;
          busy_d    = 1'b0;
          cnt_d     = 4'd0;
          pend_hi_d = 32'd0;
          pend_lo_d = 32'd0;
          pend_dz_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios plus randomized ops
// against an arithmetic reference model of HI/LO and busy latency.
module tb_md_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs_data;
  logic [31:0] e_rt_data;
  logic        d_md_use;
`ifdef MD_CANCEL_EN
  logic        md_cancel;
`endif
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_md_op   (e_md_op),
    .e_rs_data (e_rs_data),
    .e_rt_data (e_rt_data),
    .d_md_use  (d_md_use),
`ifdef MD_CANCEL_EN
    .md_cancel (md_cancel),
`endif
    .start     (start),
    .busy      (busy),
    .stall_md  (stall_md),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result of a mult/div op from plain integer arithmetic.
  task automatic model_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, p, q, r;
    logic [63:0] pu;
    eh = model_hi;
    el = model_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      4'd2: begin pu = 64'(a) * 64'(b); eh = pu[63:32]; el = pu[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
      4'd4: if (b != 0) begin eh = a % b; el = a / b; end
      default: ;
    endcase
  endtask

  task automatic clear_inputs();
    e_valid   = 1'b0;
    e_md_op   = 4'd0;
    e_rs_data = 32'd0;
    e_rt_data = 32'd0;
`ifdef MD_CANCEL_EN
    md_cancel = 1'b0;
`endif
  endtask

  // Issue one mult/div from the current (idle) cycle and follow it to commit.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic use_d);
    logic [31:0] eh, el;
    int n_busy, n_stall, exp_n;
    model_md(op, a, b, eh, el);
    exp_n = (op <= 4'd2) ? MULT_N : DIV_N;
    d_md_use  = use_d;
    e_valid   = 1'b1;
    e_md_op   = op;
    e_rs_data = a;
    e_rt_data = b;
    #1;
    n_checks++;
    if (start !== 1'b1) $display("FAIL %s_start got=%b exp=1", name, start);
    else n_pass++;
    n_stall = stall_md ? 1 : 0;
    tick();
    clear_inputs();
    n_busy = 0;
    while (busy === 1'b1 && n_busy < 40) begin
      n_busy++;
      if (stall_md === 1'b1) n_stall++;
      tick();
    end
    n_checks++;
    if (n_busy !== exp_n) $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, n_busy, exp_n);
    else n_pass++;
    n_checks++;
    if (n_stall !== (use_d ? exp_n + 1 : 0))
      $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, n_stall, use_d ? exp_n + 1 : 0);
    else n_pass++;
    n_checks++;
    if (hi !== eh || lo !== el)
      $display("FAIL %s_result got hi=%h lo=%h exp hi=%h lo=%h", name, hi, lo, eh, el);
    else n_pass++;
    model_hi = eh;
    model_lo = el;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    e_valid   = 1'b1;
    e_md_op   = 4'd1;
    e_rs_data = 32'd3;
    e_rt_data = 32'd4;
    d_md_use  = 1'b1;
`ifdef MD_CANCEL_EN
    md_cancel = 1'b0;
`endif
    tick();
    tick();
    n_checks++;
    if (start !== 1'b0 || stall_md !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_ctrl got start=%b stall=%b busy=%b exp 0 0 0", start, stall_md, busy);
    else n_pass++;
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_hilo got hi=%h lo=%h exp 0 0", hi, lo);
    else n_pass++;
    clear_inputs();
    d_md_use = 1'b0;
    reset    = 1'b0;
    tick();
    model_hi = 32'd0;
    model_lo = 32'd0;
  endtask

  task automatic test_directed();
    run_op("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA)
      $display("FAIL mult_neg_const got hi=%h lo=%h exp ffffffff fffffffa", hi, lo);
    else n_pass++;
    run_op("divu_stall", 4'd4, 32'd100, 32'd7, 1'b1);
    n_checks++;
    if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_const got hi=%0d lo=%0d exp 2 14", hi, lo);
    else n_pass++;
    n_checks++;
    if (stall_md !== 1'b0) $display("FAIL divu_stall_release got=%b exp=0", stall_md);
    else n_pass++;
    d_md_use = 1'b0;
    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    n_checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF)
      $display("FAIL div_neg_const got hi=%h lo=%h exp ffffffff fffffffd", hi, lo);
    else n_pass++;
    run_op("div_zero", 4'd3, 32'd55, 32'd0, 1'b0);
  endtask

  task automatic test_mthi_mtlo();
    e_valid   = 1'b1;
    e_md_op   = 4'd5;
    e_rs_data = 32'h1234_5678;
    #1;
    n_checks++;
    if (start !== 1'b0) $display("FAIL mthi_start got=%b exp=0", start);
    else n_pass++;
    tick();
    clear_inputs();
    model_hi = 32'h1234_5678;
    n_checks++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0)
      $display("FAIL mthi_write got hi=%h busy=%b exp 12345678 0", hi, busy);
    else n_pass++;
    e_valid   = 1'b1;
    e_md_op   = 4'd6;
    e_rs_data = 32'hCAFE_0001;
    tick();
    clear_inputs();
    model_lo = 32'hCAFE_0001;
    n_checks++;
    if (lo !== 32'hCAFE_0001) $display("FAIL mtlo_write got lo=%h exp cafe0001", lo);
    else n_pass++;
  endtask

  task automatic test_ignore_in_run();
    int n_busy;
    e_valid   = 1'b1;
    e_md_op   = 4'd1;
    e_rs_data = 32'd3;
    e_rt_data = 32'd4;
    tick();
    e_md_op   = 4'd6;
    e_rs_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (start !== 1'b0 || busy !== 1'b1) $display("FAIL run_mtlo got start=%b busy=%b exp 0 1", start, busy);
    else n_pass++;
    tick();
    e_md_op   = 4'd3;
    e_rs_data = 32'd9;
    e_rt_data = 32'd2;
    #1;
    n_checks++;
    if (start !== 1'b0) $display("FAIL run_div_start got=%b exp=0", start);
    else n_pass++;
    tick();
    clear_inputs();
    n_busy = 2;
    while (busy === 1'b1 && n_busy < 40) begin
      n_busy++;
      tick();
    end
    model_hi = 32'd0;
    model_lo = 32'd12;
    n_checks++;
    if (n_busy !== MULT_N || hi !== 32'd0 || lo !== 32'd12)
      $display("FAIL run_ignore got busy=%0d hi=%h lo=%h exp %0d 0 c", n_busy, hi, lo, MULT_N);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", 4'd2, 32'd1000, 32'd2000, 1'b1);
    run_op("b2b_b", 4'd4, 32'd1000, 32'd33, 1'b1);
    d_md_use = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    e_valid   = 1'b1;
    e_md_op   = 4'd2;
    e_rs_data = 32'hFFFF_FFFF;
    e_rt_data = 32'hFFFF_FFFF;
    tick();
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL reset_mid got busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo);
    else n_pass++;
    tick();
    reset = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL reset_nocommit got busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        ev;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      if (i % 3 != 0) op = 4'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd7;
      ev = ($urandom_range(0, 4) != 0);
      if (ev && op >= 4'd1 && op <= 4'd4) begin
        run_op("rand_md", op, a, b, 1'($urandom_range(0, 1)));
      end else begin
        e_valid   = ev;
        e_md_op   = op;
        e_rs_data = a;
        e_rt_data = b;
        #1;
        n_checks++;
        if (start !== 1'b0) $display("FAIL rand_nostart op=%0d ev=%b got=%b exp=0", op, ev, start);
        else n_pass++;
        tick();
        clear_inputs();
        if (ev && op == 4'd5) model_hi = a;
        if (ev && op == 4'd6) model_lo = a;
        n_checks++;
        if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo)
          $display("FAIL rand_move op=%0d got busy=%b hi=%h lo=%h exp 0 %h %h", op, busy, hi, lo, model_hi, model_lo);
        else n_pass++;
      end
    end
  endtask

`ifdef MD_CANCEL_EN
  task automatic test_cancel();
    logic [31:0] ph, pl;
    ph = model_hi;
    pl = model_lo;
    e_valid   = 1'b1;
    e_md_op   = 4'd1;
    e_rs_data = 32'd5;
    e_rt_data = 32'd6;
    tick();
    clear_inputs();
    tick();
    md_cancel = 1'b1;
    tick();
    md_cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== ph || lo !== pl)
      $display("FAIL cancel_run got busy=%b hi=%h lo=%h exp 0 %h %h", busy, hi, lo, ph, pl);
    else n_pass++;
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (hi !== ph || lo !== pl) $display("FAIL cancel_nocommit got hi=%h lo=%h exp %h %h", hi, lo, ph, pl);
    else n_pass++;
    e_valid   = 1'b1;
    e_md_op   = 4'd1;
    md_cancel = 1'b1;
    #1;
    n_checks++;
    if (start !== 1'b0) $display("FAIL cancel_start got=%b exp=0", start);
    else n_pass++;
    tick();
    e_md_op   = 4'd5;
    e_rs_data = 32'h0BAD_0BAD;
    tick();
    clear_inputs();
    n_checks++;
    if (busy !== 1'b0 || hi !== ph) $display("FAIL cancel_mthi got busy=%b hi=%h exp 0 %h", busy, hi, ph);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
`ifdef MD_CANCEL_EN
    test_cancel();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle controller for the multiply/divide resource in the E stage of the 5-stage pipeline.
- Accepts MD ops issued from E, computes operands into pending HI/LO, holds busy for a fixed latency, then commits HI/LO.
- Drives the D-stage stall request for any MD-class instruction (mult*, div*, mfhi/mflo, mthi/mtlo) while an op is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles after start for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles after start for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
e_valid  input  1  E-stage instruction is valid (not a bubble)
e_md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7-15 treated as none
e_rs_data  input  32  forwarded rs operand
e_rt_data  input  32  forwarded rt operand
d_md_use  input  1  D-stage instruction is MD-class
start  output  1  combinational; high in the cycle a mult/div op is accepted
busy  output  1  registered; high while an op is in flight
stall_md  output  1  combinational stall request to the hazard unit
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset: state IDLE, busy=0, counter=0, hi=0, lo=0, pending regs=0; start and stall_md evaluate to 0 while reset is high.
- States: IDLE, RUN.
- start = e_valid & (e_md_op in 1..4) & (state==IDLE).
- IDLE + start at edge: latch pending result; counter <= MULT_CYCLES or DIV_CYCLES; busy <= 1; go to RUN.
- mult: {hi,lo} pending = signed 64-bit rs*rt; multu: unsigned product.
- div: lo = signed rs/rt (truncate toward zero), hi = remainder with the sign of the dividend; divu: unsigned.
- Divide by zero: op still runs for the full DIV_CYCLES with busy high; HI/LO are left unchanged at commit.
- RUN: counter decrements each edge. On the edge where counter==1: hi/lo <= pending, busy <= 0, state IDLE.
- busy is high for exactly N cycles following the start cycle; the result is visible on hi/lo in the first cycle busy is low.
- mthi/mtlo: in IDLE with e_valid, hi (or lo) <= e_rs_data at the edge with no busy period. In RUN the op is ignored; the hazard unit guarantees it cannot occur.
- A mult/div presented in E while in RUN is ignored: no start, no state change. This is a protocol violation and the stall prevents it.
- stall_md = d_md_use & (start | busy).
- Back-to-back issue: the D-stage MD op stalls until busy falls, then proceeds to E and may start in the cycle after commit.
- Reset asserted mid-RUN: aborts immediately, discards pending, restores reset values; no commit occurs.

Optional Feature:
MD_CANCEL_EN
- Defined: adds input md_cancel (1 bit).
  - md_cancel high in RUN: state returns to IDLE at that edge, busy <= 0, hi/lo unchanged, pending discarded.
  - md_cancel high in the start cycle: suppresses the start and any mthi/mtlo write in that cycle; start reads 0.
- Not defined: the port is absent, and in-flight ops always commit.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3 -> start for 1 cycle; busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu rs=100, rt=7 with d_md_use=1 throughout -> stall_md high for 11 cycles (start + 10 busy); then lo=14, hi=2.
- div rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div with rt=0 -> busy 10 cycles, hi/lo unchanged.
- mthi 0x12345678 in IDLE -> hi=0x12345678 next edge, busy stays 0. mtlo presented while busy -> lo unchanged.
- multu 0xFFFFFFFF*0xFFFFFFFF, then reset pulsed at busy cycle 3 -> busy=0, hi=lo=0 immediately; no commit afterwards.
- MD_CANCEL_EN: mult 5*6, md_cancel at busy cycle 2 -> busy drops next edge, hi/lo keep prior values (not 0/30).
